// File: rtl/qdr2p_pkg.sv
// Shared constants for the QDR-II+ burst-of-4 controller: beat count, word
// widths, init FSM state encodings and the byte-write-select helper.
package qdr2p_pkg;

  localparam int BEATS          = 4;
  localparam int RAM_WIDTH_DFLT = 36;
  localparam int WORD_W_DFLT    = BEATS * RAM_WIDTH_DFLT;
  localparam int BWS_W          = 16;

  localparam logic [1:0] ST_WAIT_LOCK = 2'b00;
  localparam logic [1:0] ST_INIT      = 2'b01;
  localparam logic [1:0] ST_RUN       = 2'b10;

  // Byte-write selects are active low; a full burst write enables every byte lane.
  function automatic logic [BWS_W-1:0] bws_mask(input logic full_write);
    if (full_write) begin
      return 16'h0000;
    end else begin
      return 16'hffff;
    end
  endfunction

endpackage

// File: rtl/qdr2p_if.sv
// User request/return bus plus the per-clock PHY command/data bus.
// The controller sits on the slave side; the user logic and PHY on the master side.
interface qdr2p_if #(
  parameter int ADDR_BITS = 18,
  parameter int RAM_WIDTH = 36
);
  import qdr2p_pkg::*;

  localparam int DW = BEATS * RAM_WIDTH;

  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 rd_valid;
  logic [DW-1:0]        rd_data;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DW-1:0]        wr_data;
  logic [ADDR_BITS-1:0] phy_a_rd;
  logic [ADDR_BITS-1:0] phy_a_wr;
  logic                 phy_rps_n;
  logic                 phy_wps_n;
  logic [DW-1:0]        phy_d;
  logic [BWS_W-1:0]     phy_bws_n;
  logic [DW-1:0]        phy_q;
  logic                 phy_q_valid;

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, phy_q, phy_q_valid,
    output rd_valid, rd_data, phy_a_rd, phy_a_wr, phy_rps_n, phy_wps_n, phy_d, phy_bws_n
  );

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, phy_q, phy_q_valid,
    input  rd_valid, rd_data, phy_a_rd, phy_a_wr, phy_rps_n, phy_wps_n, phy_d, phy_bws_n
  );

endinterface

// File: rtl/qdr2p_init_seq.sv
// RAM power-up sequencer: synchronises PLL lock, waits INIT_CYCLES idle cycles,
// then raises rst_done. Losing lock at any time restarts the sequence.
module qdr2p_init_seq
  import qdr2p_pkg::*;
#(
  parameter int INIT_CYCLES = 2048
) (
  input  logic clk_ctl,
  input  logic rst_n,
  input  logic ext_pll_lock,
  output logic pll_lock,
  output logic rst_done
);

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);

  logic             lock_meta_r;
  logic             pll_lock_r;
  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             rst_done_r;

  // Lock synchroniser and init state machine.
  always_ff @(posedge clk_ctl or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_r <= 1'b0;
      pll_lock_r  <= 1'b0;
      state_r     <= ST_WAIT_LOCK;
      cnt_r       <= {CNT_W{1'b0}};
      rst_done_r  <= 1'b0;
    end else begin
      lock_meta_r <= ext_pll_lock;
      pll_lock_r  <= lock_meta_r;
      if (!pll_lock_r) begin
        state_r    <= ST_WAIT_LOCK;
        cnt_r      <= {CNT_W{1'b0}};
        rst_done_r <= 1'b0;
      end else begin
        case (state_r)
          ST_WAIT_LOCK: begin
            state_r    <= ST_INIT;
            cnt_r      <= {CNT_W{1'b0}};
            rst_done_r <= 1'b0;
          end
          ST_INIT: begin
            if (cnt_r == CNT_W'(INIT_CYCLES - 1)) begin
              state_r    <= ST_RUN;
              rst_done_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          ST_RUN: begin
            rst_done_r <= 1'b1;
          end
          default: begin
            state_r    <= ST_WAIT_LOCK;
            rst_done_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pll_lock = pll_lock_r;
  assign rst_done = rst_done_r;

endmodule

// File: rtl/qdr2p_controller.sv
// QDR-II+ burst-of-4 controller core: registers user requests onto the PHY bus
// one cycle later and returns read bursts in issue order with overflow/underflow flags.
module qdr2p_controller
  import qdr2p_pkg::*;
#(
  parameter int RAM_WIDTH   = 36,
  parameter int ADDR_BITS   = 18,
  parameter int INIT_CYCLES = 2048,
  parameter int MAX_OUTST   = 8
) (
  input  logic     clk_ctl,
  input  logic     rst_n,
  input  logic     ext_pll_lock,
  qdr2p_if.slave   bus,
  output logic     rst_done,
  output logic     pll_lock,
  output logic     err_unexp
);

  localparam int WORD_W = BEATS * RAM_WIDTH;
  localparam int OUT_W  = $clog2(MAX_OUTST + 1);

  logic [OUT_W-1:0] outst_r;
  logic             wr_accept_s;
  logic             rd_accept_s;
  logic             rd_drop_s;
  logic             ret_s;
  logic             unexp_s;

  qdr2p_init_seq #(.INIT_CYCLES(INIT_CYCLES)) u_init_seq (
    .clk_ctl      (clk_ctl),
    .rst_n        (rst_n),
    .ext_pll_lock (ext_pll_lock),
    .pll_lock     (pll_lock),
    .rst_done     (rst_done)
  );

  // Request acceptance and return qualification for this cycle.
  always_comb begin
    wr_accept_s = bus.wr_en & rst_done;
    rd_accept_s = 1'b0;
    rd_drop_s   = 1'b0;
    if (bus.rd_en && rst_done) begin
      if (outst_r == OUT_W'(MAX_OUTST)) begin
        rd_drop_s = 1'b1;
      end else begin
        rd_accept_s = 1'b1;
      end
    end else begin
      rd_accept_s = 1'b0;
    end
    ret_s   = bus.phy_q_valid & (outst_r != {OUT_W{1'b0}});
    unexp_s = bus.phy_q_valid & (outst_r == {OUT_W{1'b0}});
  end

  // PHY command/data registers, read return path and outstanding-read tracking.
  always_ff @(posedge clk_ctl or negedge rst_n) begin
    if (!rst_n) begin
      bus.phy_wps_n <= 1'b1;
      bus.phy_rps_n <= 1'b1;
      bus.phy_bws_n <= bws_mask(1'b0);
      bus.phy_a_wr  <= {ADDR_BITS{1'b0}};
      bus.phy_a_rd  <= {ADDR_BITS{1'b0}};
      bus.phy_d     <= {WORD_W{1'b0}};
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= {WORD_W{1'b0}};
      err_unexp     <= 1'b0;
      outst_r       <= {OUT_W{1'b0}};
    end else begin
      bus.phy_wps_n <= ~wr_accept_s;
      bus.phy_bws_n <= bws_mask(wr_accept_s);
      if (wr_accept_s) begin
        bus.phy_a_wr <= bus.wr_addr;
        bus.phy_d    <= bus.wr_data;
      end
      bus.phy_rps_n <= ~rd_accept_s;
      if (rd_accept_s) begin
        bus.phy_a_rd <= bus.rd_addr;
      end
      bus.rd_valid <= ret_s;
      if (ret_s) begin
        bus.rd_data <= bus.phy_q;
      end
      if (unexp_s || rd_drop_s) begin
        err_unexp <= 1'b1;
      end
      // Lock loss discards in-flight reads; the RAM will not return them.
      if (!pll_lock) begin
        outst_r <= {OUT_W{1'b0}};
      end else begin
        outst_r <= outst_r + OUT_W'(rd_accept_s) - OUT_W'(ret_s);
      end
    end
  end

endmodule

// File: tb/tb_qdr2p_controller.sv
// Bench for qdr2p_controller: behavioural PHY+RAM with 3-cycle read return and a
// user-level reference model (memory + ordered return queue) checked every cycle.
module tb_qdr2p_controller;

  localparam int AW = 18;
  localparam int RW = 36;
  localparam int WW = 4 * RW;
  localparam int NI = 64;
  localparam int MO = 8;

  logic clk_ctl = 1'b0;
  logic rst_n = 1'b0;
  logic ext_pll_lock = 1'b0;
  logic rst_done, pll_lock, err_unexp;

  qdr2p_if #(.ADDR_BITS(AW), .RAM_WIDTH(RW)) bus ();

  qdr2p_controller #(.RAM_WIDTH(RW), .ADDR_BITS(AW), .INIT_CYCLES(NI), .MAX_OUTST(MO)) dut (
    .clk_ctl      (clk_ctl),
    .rst_n        (rst_n),
    .ext_pll_lock (ext_pll_lock),
    .bus          (bus),
    .rst_done     (rst_done),
    .pll_lock     (pll_lock),
    .err_unexp    (err_unexp)
  );

  always #5 clk_ctl = ~clk_ctl;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] rnd_word();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[WW-1:0];
  endfunction

  // ---------------- PHY + RAM model ----------------
  logic [WW-1:0] phy_mem [logic [AW-1:0]];
  logic [WW-1:0] pq[$];
  int            pd[$];
  int            cyc = 0;
  bit            hold = 0;
  bit            force_unexp = 0;

  initial begin : phy_model
    bus.phy_q_valid = 1'b0;
    bus.phy_q = '0;
    forever begin
      @(negedge clk_ctl);
      if (!rst_n) begin
        pq.delete();
        pd.delete();
      end else begin
        if (bus.phy_wps_n == 1'b0) phy_mem[bus.phy_a_wr] = bus.phy_d;
        if (bus.phy_rps_n == 1'b0) begin
          pq.push_back(phy_mem.exists(bus.phy_a_rd) ? phy_mem[bus.phy_a_rd] : '0);
          pd.push_back(cyc + 3);
        end
      end
      cyc++;
      @(posedge clk_ctl);
      #1;
      if (force_unexp) begin
        bus.phy_q_valid = 1'b1;
        bus.phy_q = rnd_word();
      end else if (pq.size() > 0 && !hold && pd[0] <= cyc) begin
        bus.phy_q_valid = 1'b1;
        bus.phy_q = pq.pop_front();
        void'(pd.pop_front());
      end else begin
        bus.phy_q_valid = 1'b0;
      end
    end
  end

  // ---------------- user-level reference model ----------------
  logic [WW-1:0] ref_mem [logic [AW-1:0]];
  logic [WW-1:0] exp_q[$];
  int            lock_cnt = 0;
  int            m_outst = 0;
  logic [WW-1:0] m_rd_data = '0;
  logic          m_err = 1'b0;
  logic          e_rv = 1'b0, e_rps = 1'b1, e_wps = 1'b1;
  logic [AW-1:0] e_a_rd = '0, e_a_wr = '0;
  logic [WW-1:0] e_d = '0;
  logic          p_rst = 1'b0, p_rd = 1'b0, p_wr = 1'b0, p_qv = 1'b0, p_ext = 1'b0;
  logic [AW-1:0] p_ra = '0, p_wa = '0;
  logic [WW-1:0] p_wd = '0;

  always @(negedge clk_ctl) begin : compare_p
    logic rdone, rd_ok, wr_ok, ret;
    if (!rst_n) begin
      lock_cnt = 0; m_outst = 0; exp_q.delete(); m_rd_data = '0; m_err = 1'b0;
      e_rv = 1'b0; e_rps = 1'b1; e_wps = 1'b1;
      chk("rst_phy_a_rd", bus.phy_a_rd, '0);
      chk("rst_phy_a_wr", bus.phy_a_wr, '0);
      chk("rst_phy_d", bus.phy_d, '0);
    end else if (p_rst) begin
      rdone = (lock_cnt >= NI + 3);
      wr_ok = p_wr && rdone;
      rd_ok = p_rd && rdone && (m_outst < MO);
      ret   = p_qv && (m_outst > 0);
      if ((p_rd && rdone && m_outst >= MO) || (p_qv && m_outst == 0)) m_err = 1'b1;
      if (wr_ok) ref_mem[p_wa] = p_wd;
      if (ret) m_rd_data = exp_q.pop_front();
      if (rd_ok) exp_q.push_back(ref_mem.exists(p_ra) ? ref_mem[p_ra] : '0);
      m_outst = m_outst + int'(rd_ok) - int'(ret);
      e_rv = ret; e_rps = ~rd_ok; e_wps = ~wr_ok;
      if (rd_ok) e_a_rd = p_ra;
      if (wr_ok) begin e_a_wr = p_wa; e_d = p_wd; end
      if (p_ext) begin
        if (lock_cnt < 1000000) lock_cnt++;
      end else begin
        lock_cnt = 0;
      end
    end
    chk("rst_done", rst_done, lock_cnt >= NI + 3);
    chk("pll_lock", pll_lock, lock_cnt >= 2);
    chk("rd_valid", bus.rd_valid, e_rv);
    chk("rd_data", bus.rd_data, m_rd_data);
    chk("phy_rps_n", bus.phy_rps_n, e_rps);
    chk("phy_wps_n", bus.phy_wps_n, e_wps);
    chk("phy_bws_n", bus.phy_bws_n, e_wps ? 16'hffff : 16'h0000);
    chk("err_unexp", err_unexp, m_err);
    if (!e_rps) chk("phy_a_rd", bus.phy_a_rd, e_a_rd);
    if (!e_wps) begin
      chk("phy_a_wr", bus.phy_a_wr, e_a_wr);
      chk("phy_d", bus.phy_d, e_d);
    end
    p_rst = rst_n; p_rd = bus.rd_en; p_ra = bus.rd_addr; p_wr = bus.wr_en;
    p_wa = bus.wr_addr; p_wd = bus.wr_data; p_qv = bus.phy_q_valid; p_ext = ext_pll_lock;
  end

  // ---------------- stimulus ----------------
  task automatic cyc_req(input logic re, input logic [AW-1:0] ra, input logic we,
                         input logic [AW-1:0] wa, input logic [WW-1:0] wd);
    @(posedge clk_ctl);
    #1;
    bus.rd_en = re; bus.rd_addr = ra; bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_req(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic wait_rd(input string nm, input logic [WW-1:0] exp);
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_ctl);
      if (bus.rd_valid) begin
        got = 1;
        chk(nm, bus.rd_data, exp);
      end
    end
    if (!got) begin
      n_vec++; n_bad++;
      $display("FAIL %s: got no rd_valid expected one within 20 cycles", nm);
    end
  endtask

  task automatic wait_init(input string nm);
    bit got;
    got = 0;
    for (int i = 0; i < NI + 20 && !got; i++) begin
      @(negedge clk_ctl);
      if (rst_done) got = 1;
    end
    if (!got) begin
      n_vec++; n_bad++;
      $display("FAIL %s: got rst_done=0 expected 1 within budget", nm);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [WW-1:0] D1 = 144'h0_deadbeef_1_baadc0de_2_feedface_3_c0def00d;
  localparam logic [WW-1:0] D2 = 144'ha_41414141_b_69696969_c_cccccccc_d_cd80cd80;
  localparam logic [WW-1:0] D3 = 144'he_eeeeeeee_f_ffffffff_0_00000000_1_11111111;

  initial begin : stim
    int k;
    bit seen;
    logic [35:0] b;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    repeat (3) @(posedge clk_ctl);
    #1 rst_n = 1'b1;

    // 3: requests before lock/init are dropped; rst_done latency after lock
    for (int i = 0; i < 5; i++) cyc_req(1'b1, 18'h00001, 1'b1, 18'h00001, rnd_word());
    @(posedge clk_ctl);
    #1 ext_pll_lock = 1'b1;
    k = 0;
    seen = 0;
    while (!seen && k < NI + 20) begin
      @(posedge clk_ctl);
      #1;
      bus.rd_en = 1'($urandom); bus.rd_addr = 18'($urandom_range(0, 3));
      bus.wr_en = 1'($urandom); bus.wr_addr = 18'($urandom_range(0, 3)); bus.wr_data = rnd_word();
      @(negedge clk_ctl);
      k++;
      if (rst_done) seen = 1;
    end
    chk("init_latency_in_window", (k >= NI + 2 && k <= NI + 3), 1'b1);
    idle(8);

    // 1: single write then read
    cyc_req(1'b0, '0, 1'b1, 18'h0beef, D1);
    cyc_req(1'b1, 18'h0beef, 1'b0, '0, '0);
    idle(1);
    wait_rd("t1_read", D1);

    // 2: back-to-back writes, back-to-back reads
    cyc_req(1'b0, '0, 1'b1, 18'h0feed, D2);
    cyc_req(1'b0, '0, 1'b1, 18'h0face, D3);
    cyc_req(1'b1, 18'h0feed, 1'b0, '0, '0);
    cyc_req(1'b1, 18'h0face, 1'b0, '0, '0);
    idle(1);
    wait_rd("t2_first", D2);
    wait_rd("t2_second", D3);
    idle(4);

    // 6: nine reads with returns held: ninth dropped, eight in order
    for (int i = 0; i < 8; i++) begin
      b = 36'h012345600 + 36'(i);
      cyc_req(1'b0, '0, 1'b1, 18'h00100 + 18'(i), {b, b, b, b});
    end
    idle(2);
    chk("t6_err_before", err_unexp, 1'b0);
    @(negedge clk_ctl);
    hold = 1;
    for (int i = 0; i < 9; i++) cyc_req(1'b1, 18'h00100 + 18'(i), 1'b0, '0, '0);
    idle(4);
    chk("t6_reads_issued", 144'(pq.size()), 144'd8);
    chk("t6_err_after_drop", err_unexp, 1'b1);
    @(negedge clk_ctl);
    hold = 0;
    for (int i = 0; i < 8; i++) begin
      b = 36'h012345600 + 36'(i);
      wait_rd("t6_return", {b, b, b, b});
    end
    idle(4);

    // 5: reset with two reads outstanding
    cyc_req(1'b1, 18'h0beef, 1'b1, 18'h00222, D2);
    cyc_req(1'b1, 18'h0feed, 1'b0, '0, '0);
    idle(1);
    @(posedge clk_ctl);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rps_n", bus.phy_rps_n, 1'b1);
    chk("t5_wps_n", bus.phy_wps_n, 1'b1);
    chk("t5_bws_n", bus.phy_bws_n, 16'hffff);
    chk("t5_rd_valid", bus.rd_valid, 1'b0);
    chk("t5_rd_data", bus.rd_data, '0);
    chk("t5_phy_d", bus.phy_d, '0);
    chk("t5_rst_done", rst_done, 1'b0);
    chk("t5_pll_lock", pll_lock, 1'b0);
    chk("t5_err", err_unexp, 1'b0);
    repeat (3) @(posedge clk_ctl);
    #1 rst_n = 1'b1;
    wait_init("t5_reinit");
    idle(8);

    // 4: return with nothing outstanding
    chk("t4_err_before", err_unexp, 1'b0);
    @(negedge clk_ctl);
    force_unexp = 1;
    @(negedge clk_ctl);
    force_unexp = 0;
    chk("t4_no_rd_valid", bus.rd_valid, 1'b0);
    idle(2);
    chk("t4_err_after", err_unexp, 1'b1);

    // randomized traffic with address collisions
    for (int i = 0; i < 400; i++)
      cyc_req(1'($urandom), 18'($urandom_range(0, 7)), 1'($urandom), 18'($urandom_range(0, 7)), rnd_word());
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
